// File: rtl/ram_station_q.sv
// ram_station_q: in-order memory reservation queue with broadcast wakeup; head issues only when ready.
// Optional synchronous queue flush port enabled by defining RSQ_FLUSH_EN.
module ram_station_q #(
   parameter int DEPTH   = 4,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 5,
   parameter int OP_W    = 1,
   parameter int ID_BASE = 8
) (
   input  logic                         clk,
   input  logic                         nRST,
   input  logic                         WEN,
   input  logic [DATA_W-1:0]            dataIn,
   input  logic [TAG_W-1:0]             labelIn,
   input  logic [OP_W-1:0]              opIn,
   output logic                         isFull,
   output logic [TAG_W-1:0]             allocId,
   input  logic                         BCEN,
   input  logic [TAG_W-1:0]             BClabel,
   input  logic [DATA_W-1:0]            BCdata,
   output logic                         require,
   input  logic                         requireAC,
`ifdef RSQ_FLUSH_EN
   input  logic                         flush,
`endif
   output logic [OP_W-1:0]              opOut,
   output logic [DATA_W-1:0]            dataOut,
   output logic [TAG_W-1:0]             labelOut,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DATA_W-1:0] data_q  [DEPTH];
   logic [DATA_W-1:0] data_d  [DEPTH];
   logic [TAG_W-1:0]  label_q [DEPTH];
   logic [TAG_W-1:0]  label_d [DEPTH];
   logic [OP_W-1:0]   op_q    [DEPTH];
   logic [OP_W-1:0]   op_d    [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              head_ok, pop, push, bc_hit_in;

   assign head_ok   = valid_q[head_q];
   assign require   = head_ok && label_q[head_q] == '0;
   assign pop       = require && requireAC;
   assign isFull    = count_q == CW'(DEPTH) && !pop;
   assign push      = WEN && !isFull;
   assign allocId   = TAG_W'(ID_BASE) + TAG_W'(tail_q);
   assign opOut     = head_ok ? op_q[head_q] : '0;
   assign dataOut   = head_ok ? data_q[head_q] : '0;
   assign labelOut  = head_ok ? TAG_W'(ID_BASE) + TAG_W'(head_q) : '0;
   assign count     = count_q;
   // An operand arriving on the bus in its push cycle is captured directly.
   assign bc_hit_in = BCEN && BClabel != '0 && labelIn == BClabel;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      label_d = label_q;
      op_d    = op_q;
      head_d  = head_q;
      tail_d  = tail_q;
      for (int i = 0; i < DEPTH; i++)
         if (valid_q[i] && BCEN && BClabel != '0 && label_q[i] == BClabel) begin
            data_d[i]  = BCdata;
            label_d[i] = '0;
         end
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d = head_q == PW'(DEPTH-1) ? '0 : head_q + PW'(1);
      end
      // Push after pop so a full-queue push into the slot just freed wins.
      if (push) begin
         valid_d[tail_q] = 1'b1;
         data_d[tail_q]  = bc_hit_in ? BCdata : dataIn;
         label_d[tail_q] = bc_hit_in ? '0 : labelIn;
         op_d[tail_q]    = opIn;
         tail_d = tail_q == PW'(DEPTH-1) ? '0 : tail_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
`ifdef RSQ_FLUSH_EN
      if (flush) begin
         valid_d = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge nRST)
      if (!nRST) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i]  <= '0;
            label_q[i] <= '0;
            op_q[i]    <= '0;
         end
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         label_q <= label_d;
         op_q    <= op_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
endmodule

// File: tb/tb_ram_station_q.sv
// tb_ram_station_q: directed vector table plus randomized scoreboard run for ram_station_q.
module tb_ram_station_q;
   logic        clk = 1'b0, nRST = 1'b0;
   logic        WEN = 1'b0, BCEN = 1'b0, requireAC = 1'b0;
   logic [31:0] dataIn = '0, BCdata = '0, dataOut;
   logic [4:0]  labelIn = '0, BClabel = '0, allocId, labelOut;
   logic        opIn = 1'b0, opOut, isFull, require;
   logic [2:0]  count;
`ifdef RSQ_FLUSH_EN
   logic        flush = 1'b0;
`endif
   int n_vec = 0, n_bad = 0;

   ram_station_q dut (
      .clk(clk), .nRST(nRST), .WEN(WEN), .dataIn(dataIn), .labelIn(labelIn), .opIn(opIn),
      .isFull(isFull), .allocId(allocId), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
      .require(require), .requireAC(requireAC),
`ifdef RSQ_FLUSH_EN
      .flush(flush),
`endif
      .opOut(opOut), .dataOut(dataOut), .labelOut(labelOut), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst; bit wen; logic [31:0] din; logic [4:0] lin; logic op;
      bit bcen; logic [4:0] bcl; logic [31:0] bcd; bit rac;
      bit e_full; logic [4:0] e_alloc; bit e_req; logic e_op;
      logic [31:0] e_dout; logic [4:0] e_lout; logic [2:0] e_cnt;
   } vec_t;

   typedef struct { logic op; logic [31:0] d; logic [4:0] l; logic [4:0] id; } ent_t;

   vec_t tv[$];
   ent_t mq[$];

   function automatic vec_t mk(bit rst, bit wen, logic [31:0] din, logic [4:0] lin, logic op,
                               bit bcen, logic [4:0] bcl, logic [31:0] bcd, bit rac,
                               bit full, logic [4:0] alloc, bit req, logic opo,
                               logic [31:0] dout, logic [4:0] lout, logic [2:0] cnt);
      vec_t v;
      v.rst = rst; v.wen = wen; v.din = din; v.lin = lin; v.op = op;
      v.bcen = bcen; v.bcl = bcl; v.bcd = bcd; v.rac = rac;
      v.e_full = full; v.e_alloc = alloc; v.e_req = req; v.e_op = opo;
      v.e_dout = dout; v.e_lout = lout; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      #2;
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_require", 32'(require), 0);
      chk("async_rst_isFull", 32'(isFull), 0);
      chk("async_rst_allocId", 32'(allocId), 8);
      chk("async_rst_labelOut", 32'(labelOut), 0);
      @(posedge clk);
      #1 nRST = 1'b1;
   endtask

   task automatic drive(input bit wen, input logic [31:0] din, input logic [4:0] lin, input logic op,
                        input bit bcen, input logic [4:0] bcl, input logic [31:0] bcd, input bit rac);
      WEN = wen; dataIn = din; labelIn = lin; opIn = op;
      BCEN = bcen; BClabel = bcl; BCdata = bcd; requireAC = rac;
   endtask

   initial begin
      bit exp_pop, exp_full, hit;
      logic [4:0] tail_id;
      ent_t e;
      // Directed table: expected outputs are sampled before the edge that applies the inputs.
      tv.push_back(mk(0,1,'h11,0,1, 0,0,0,   0, 0, 8,0,0,    0, 0,0));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   0, 0, 9,1,1,'h11, 8,1));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   1, 0, 9,1,1,'h11, 8,1));
      tv.push_back(mk(0,1,0,3,0,    0,0,0,   0, 0, 9,0,0,    0, 0,0));
      tv.push_back(mk(0,0,0,0,0,    1,3,'hAB,0, 0,10,0,0,    0, 9,1));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   0, 0,10,1,0,'hAB, 9,1));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   1, 0,10,1,0,'hAB, 9,1));
      tv.push_back(mk(0,1,0,5,0,    1,5,7,   0, 0,10,0,0,    0, 0,0));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   0, 0,11,1,0,    7,10,1));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   1, 0,11,1,0,    7,10,1));
      tv.push_back(mk(0,1,0,2,0,    0,0,0,   0, 0,11,0,0,    0, 0,0));
      tv.push_back(mk(0,1,'h22,0,0, 0,0,0,   0, 0, 8,0,0,    0,11,1));
      tv.push_back(mk(0,0,0,0,0,    1,7,'h99,1, 0, 9,0,0,    0,11,2));
      tv.push_back(mk(0,0,0,0,0,    1,2,'h55,1, 0, 9,0,0,    0,11,2));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   1, 0, 9,1,0,'h55,11,2));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   1, 0, 9,1,0,'h22, 8,1));
      tv.push_back(mk(1,1,1,0,0,    0,0,0,   0, 0, 8,0,0,    0, 0,0));
      tv.push_back(mk(0,1,2,0,0,    0,0,0,   0, 0, 9,1,0,    1, 8,1));
      tv.push_back(mk(0,1,3,0,0,    0,0,0,   0, 0,10,1,0,    1, 8,2));
      tv.push_back(mk(0,1,4,0,0,    0,0,0,   0, 0,11,1,0,    1, 8,3));
      tv.push_back(mk(0,1,5,0,0,    0,0,0,   0, 1, 8,1,0,    1, 8,4));
      tv.push_back(mk(0,1,6,0,0,    0,0,0,   1, 0, 8,1,0,    1, 8,4));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   0, 1, 9,1,0,    2, 9,4));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   1, 0, 9,1,0,    2, 9,4));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   1, 0, 9,1,0,    3,10,3));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   1, 0, 9,1,0,    4,11,2));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   1, 0, 9,1,0,    6, 8,1));
      tv.push_back(mk(0,0,0,0,0,    0,0,0,   0, 0, 9,0,0,    0, 0,0));

      #1 do_reset();
      foreach (tv[i]) begin
         if (tv[i].rst) do_reset();
         drive(tv[i].wen, tv[i].din, tv[i].lin, tv[i].op, tv[i].bcen, tv[i].bcl, tv[i].bcd, tv[i].rac);
         @(negedge clk);
         chk($sformatf("v%0d_isFull", i), 32'(isFull), 32'(tv[i].e_full));
         chk($sformatf("v%0d_allocId", i), 32'(allocId), 32'(tv[i].e_alloc));
         chk($sformatf("v%0d_require", i), 32'(require), 32'(tv[i].e_req));
         chk($sformatf("v%0d_opOut", i), 32'(opOut), 32'(tv[i].e_op));
         chk($sformatf("v%0d_dataOut", i), dataOut, tv[i].e_dout);
         chk($sformatf("v%0d_labelOut", i), 32'(labelOut), 32'(tv[i].e_lout));
         chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].e_cnt));
         @(posedge clk);
         #1;
      end

      // Randomized run against an in-order scoreboard with broadcast wakeup.
      drive(0,0,0,0,0,0,0,0);
      do_reset();
      tail_id = 8;
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0,99) < 60, $urandom, $urandom_range(0,1) ? 5'd0 : 5'($urandom_range(1,3)),
               1'($urandom_range(0,1)), $urandom_range(0,99) < 40, 5'($urandom_range(0,3)), $urandom,
               $urandom_range(0,99) < 50);
         @(negedge clk);
         exp_pop  = mq.size() > 0 && mq[0].l == 0 && requireAC;
         exp_full = mq.size() == 4 && !exp_pop;
         chk("rnd_count", 32'(count), 32'(mq.size()));
         chk("rnd_isFull", 32'(isFull), 32'(exp_full));
         chk("rnd_allocId", 32'(allocId), 32'(tail_id));
         chk("rnd_require", 32'(require), 32'(mq.size() > 0 && mq[0].l == 0));
         chk("rnd_labelOut", 32'(labelOut), mq.size() > 0 ? 32'(mq[0].id) : 0);
         if (exp_pop) begin
            e = mq.pop_front();
            chk("rnd_pop_data", dataOut, e.d);
            chk("rnd_pop_op", 32'(opOut), 32'(e.op));
         end
         if (BCEN && BClabel != 0)
            foreach (mq[i])
               if (mq[i].l == BClabel) begin
                  mq[i].d = BCdata;
                  mq[i].l = 0;
               end
         if (WEN && !exp_full) begin
            hit  = BCEN && BClabel != 0 && labelIn == BClabel;
            e.op = opIn;
            e.d  = hit ? BCdata : dataIn;
            e.l  = hit ? 5'd0 : labelIn;
            e.id = tail_id;
            mq.push_back(e);
            tail_id = tail_id == 11 ? 5'd8 : tail_id + 5'd1;
         end
         @(posedge clk);
         #1;
      end

`ifdef RSQ_FLUSH_EN
      drive(0,0,0,0,0,0,0,0);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1, 32'(k + 1), 0, 0, 0, 0, 0, 0);
         @(posedge clk);
         #1;
      end
      drive(1, 'h77, 0, 0, 0, 0, 0, 0);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_pre_count", 32'(count), 3);
      @(posedge clk);
      #1;
      flush = 1'b0;
      drive(0,0,0,0,0,0,0,0);
      @(negedge clk);
      chk("flush_count", 32'(count), 0);
      chk("flush_require", 32'(require), 0);
      chk("flush_allocId", 32'(allocId), 8);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
